// File: rtl/tpu_seq_ctrl.sv
// Job sequencer for the naive TPU datapath. It runs reshape, then compute, then
// write-back, and reports status and a performance cycle count to the host.
module tpu_seq_ctrl #(
    parameter int DIM_W   = 16,
    parameter int TIMEOUT = 1048575,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_start,
    input  logic [DIM_W-1:0] host_M,
    input  logic [DIM_W-1:0] host_N,
    input  logic [DIM_W-1:0] host_K,
    input  logic             host_abort,
    output logic [DIM_W-1:0] M,
    output logic [DIM_W-1:0] N,
    output logic [DIM_W-1:0] K,
    output logic             reshape_start,
    input  logic             FM_reshape_finish,
    input  logic             W_reshape_finish,
    output logic             comp_start,
    input  logic             comp_finish,
    output logic             wb_start,
    input  logic             wb_finish,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CHECK     = 4'd1;
    localparam logic [3:0] S_RS_LAUNCH = 4'd2;
    localparam logic [3:0] S_RS_WAIT   = 4'd3;
    localparam logic [3:0] S_CP_LAUNCH = 4'd4;
    localparam logic [3:0] S_CP_WAIT   = 4'd5;
    localparam logic [3:0] S_WB_LAUNCH = 4'd6;
    localparam logic [3:0] S_WB_WAIT   = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;
    localparam logic [3:0] S_ERR       = 4'd9;

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_ZERO  = 2'd1;
    localparam logic [1:0] E_TMO   = 2'd2;
    localparam logic [1:0] E_ABORT = 2'd3;

    // The timer only has to count up to TIMEOUT-1 before the abort fires.
    localparam int              TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

    logic [3:0]       state, state_nxt;
    logic [1:0]       code_nxt;
    logic [TMR_W-1:0] timer;
    logic             fm_ok, w_ok;
    logic             fm_seen, w_seen;
    logic             tmo, wait_state, accept, abortable;

    assign fm_seen    = fm_ok | FM_reshape_finish;
    assign w_seen     = w_ok  | W_reshape_finish;
    assign tmo        = (timer == TMO_LAST);
    assign wait_state = (state == S_RS_WAIT) || (state == S_CP_WAIT) || (state == S_WB_WAIT);
    assign accept     = (state == S_IDLE) && host_start;
    assign abortable  = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        code_nxt  = E_NONE;
        case (state)
            S_IDLE:      if (host_start) state_nxt = S_CHECK;
            S_CHECK: begin
                if ((M == '0) || (N == '0) || (K == '0)) begin
                    state_nxt = S_ERR;
                    code_nxt  = E_ZERO;
                end else begin
                    state_nxt = S_RS_LAUNCH;
                end
            end
            S_RS_LAUNCH: state_nxt = S_RS_WAIT;
            S_RS_WAIT: begin
                if (fm_seen && w_seen) state_nxt = S_CP_LAUNCH;
                else if (tmo) begin
                    state_nxt = S_ERR;
                    code_nxt  = E_TMO;
                end
            end
            S_CP_LAUNCH: state_nxt = S_CP_WAIT;
            S_CP_WAIT: begin
                if (comp_finish) state_nxt = S_WB_LAUNCH;
                else if (tmo) begin
                    state_nxt = S_ERR;
                    code_nxt  = E_TMO;
                end
            end
            S_WB_LAUNCH: state_nxt = S_WB_WAIT;
            S_WB_WAIT: begin
                if (wb_finish) state_nxt = S_DONE;
                else if (tmo) begin
                    state_nxt = S_ERR;
                    code_nxt  = E_TMO;
                end
            end
            S_DONE:      state_nxt = S_IDLE;
            S_ERR:       state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        // Abort outranks any finish or timeout seen in the same cycle.
        if (host_abort && abortable) begin
            state_nxt = S_ERR;
            code_nxt  = E_ABORT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            reshape_start <= 1'b0;
            comp_start    <= 1'b0;
            wb_start      <= 1'b0;
            timer         <= '0;
            fm_ok         <= 1'b0;
            w_ok          <= 1'b0;
            M             <= '0;
            N             <= '0;
            K             <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= E_NONE;
            cycle_cnt     <= '0;
        end else begin
            state         <= state_nxt;
            reshape_start <= (state_nxt == S_RS_LAUNCH);
            comp_start    <= (state_nxt == S_CP_LAUNCH);
            wb_start      <= (state_nxt == S_WB_LAUNCH);
            timer         <= wait_state ? timer + 1'b1 : '0;

            // Finish levels are ignored in the launch cycle, when they may still be stale.
            if (state == S_RS_WAIT) begin
                fm_ok <= fm_seen;
                w_ok  <= w_seen;
            end else begin
                fm_ok <= 1'b0;
                w_ok  <= 1'b0;
            end

            if (accept) begin
                M         <= host_M;
                N         <= host_N;
                K         <= host_K;
                busy      <= 1'b1;
                done      <= 1'b0;
                err       <= 1'b0;
                err_code  <= E_NONE;
                cycle_cnt <= '0;
            end else begin
                if (busy && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 1'b1;
                if ((state_nxt == S_ERR) && (state != S_ERR)) err_code <= code_nxt;
                if (state == S_DONE) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                if (state == S_ERR) begin
                    err  <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed bench for tpu_seq_ctrl: behavioural sub-block models with programmable
// finish delays and stale finish levels, plus hand-computed phase timing.
module tb_tpu_seq_ctrl;

    localparam int DIM_W = 16;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             host_start = 1'b0;
    logic             host_abort = 1'b0;
    logic [DIM_W-1:0] host_M = '0, host_N = '0, host_K = '0;
    logic [DIM_W-1:0] M, N, K;
    logic             reshape_start, comp_start, wb_start;
    logic             FM_reshape_finish, W_reshape_finish, comp_finish, wb_finish;
    logic             busy, done, err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] cycle_cnt;

    tpu_seq_ctrl #(.DIM_W(DIM_W), .TIMEOUT(100), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .host_start(host_start), .host_M(host_M), .host_N(host_N), .host_K(host_K),
        .host_abort(host_abort),
        .M(M), .N(N), .K(K),
        .reshape_start(reshape_start),
        .FM_reshape_finish(FM_reshape_finish), .W_reshape_finish(W_reshape_finish),
        .comp_start(comp_start), .comp_finish(comp_finish),
        .wb_start(wb_start), .wb_finish(wb_finish),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Sub-block models: index 0 FM, 1 W, 2 compute, 3 write-back. Delay 0 = never finish.
    int         dly [4];
    int         cnt [4];
    bit         armed [4];
    logic [3:0] fin = 4'b0000;
    assign FM_reshape_finish = fin[0];
    assign W_reshape_finish  = fin[1];
    assign comp_finish       = fin[2];
    assign wb_finish         = fin[3];

    // Monitor counters (only written here; the main block snapshots them).
    int   cyc = 0;
    int   n_rs = 0, n_cp = 0, n_wb = 0, n_busy = 0;
    int   t_rs = 0, t_cp = 0, t_wb = 0;
    int   t_bfall = -1, t_drise = -2;
    logic pbusy = 1'b0, pdone = 1'b0;

    always @(negedge clk) begin
        logic [3:0] st;
        cyc++;
        if (reshape_start) begin n_rs++; t_rs = cyc; end
        if (comp_start)    begin n_cp++; t_cp = cyc; end
        if (wb_start)      begin n_wb++; t_wb = cyc; end
        if (busy) n_busy++;
        if (pbusy && !busy) t_bfall = cyc;
        if (!pdone && done) t_drise = cyc;
        pbusy = busy;
        pdone = done;
        // A finish level stays stale through the launch cycle, then drops
        // and rises again dly cycles after the start pulse.
        st = {wb_start, comp_start, reshape_start, reshape_start};
        for (int i = 0; i < 4; i++) begin
            if (st[i]) begin
                armed[i] = 1'b1;
                cnt[i]   = dly[i];
            end else if (armed[i]) begin
                if (dly[i] == 0) fin[i] = 1'b0;
                else begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        fin[i]   = 1'b1;
                        armed[i] = 1'b0;
                    end else begin
                        fin[i] = 1'b0;
                    end
                end
            end
        end
    end

    int a_cyc, x_cyc, b_rs, b_cp, b_wb, b_busy;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_dly(input int d_fm, input int d_w, input int d_cp, input int d_wb);
        dly[0] = d_fm;
        dly[1] = d_w;
        dly[2] = d_cp;
        dly[3] = d_wb;
    endtask

    task automatic launch(input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] n,
                          input logic [DIM_W-1:0] k);
        host_M = m;
        host_N = n;
        host_K = k;
        host_start = 1'b1;
        a_cyc  = cyc;
        b_rs   = n_rs;
        b_cp   = n_cp;
        b_wb   = n_wb;
        b_busy = n_busy;
        step();
        host_start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n;
        n = 0;
        while (!(done || err) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_finished"}, 64'(done | err), 64'd1);
    endtask

    task automatic wait_pulse(input string tag, input int base, input bit is_cp, input int budget);
        int n;
        n = 0;
        while (((is_cp ? n_cp : n_rs) == base) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_pulse_seen"}, 64'((is_cp ? n_cp : n_rs) - base), 64'd1);
    endtask

    task automatic run_job(input string tag, input int d_fm, input int d_w, input int d_cp,
                           input int d_wb, input int exp_gap, input int exp_cnt);
        set_dly(d_fm, d_w, d_cp, d_wb);
        launch(16'd2, 16'd3, 16'd5);
        wait_end(tag, 300);
        check({tag, "_rs_to_cp_gap"}, 64'(t_cp - t_rs), 64'(exp_gap));
        check({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'(exp_cnt));
        check({tag, "_done"}, 64'({done, err}), 64'b10);
        check({tag, "_pulses"}, 64'((n_rs - b_rs) + (n_cp - b_cp) + (n_wb - b_wb)), 64'd3);
    endtask

    initial begin
        set_dly(1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cnt[i]   = 0;
            armed[i] = 1'b0;
        end

        // Reset state
        step();
        step();
        check("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_dims", 64'({M, N, K}), 64'd0);
        check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("rst_pulses", 64'({reshape_start, comp_start, wb_start}), 64'd0);
        rst = 1'b0;
        step();

        // Normal job with a host_start issued mid-job that must be ignored
        set_dly(20, 25, 40, 10);
        launch(16'd8, 16'd4, 16'd8);
        check("j1_busy_after_start", 64'(busy), 64'd1);
        wait_pulse("j1_cp", b_cp, 1'b1, 100);
        step();
        step();
        step();
        host_M = 16'd3;
        host_N = 16'd3;
        host_K = 16'd3;
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        wait_end("j1", 200);
        check("j1_dims", 64'({M, N, K}), {16'd0, 16'd8, 16'd4, 16'd8});
        check("j1_rs_pulses", 64'(n_rs - b_rs), 64'd1);
        check("j1_cp_pulses", 64'(n_cp - b_cp), 64'd1);
        check("j1_wb_pulses", 64'(n_wb - b_wb), 64'd1);
        check("j1_rs_at", 64'(t_rs - a_cyc), 64'd2);
        check("j1_rs_to_cp_gap", 64'(t_cp - t_rs), 64'd26);
        check("j1_cp_to_wb_gap", 64'(t_wb - t_cp), 64'd41);
        check("j1_done_err_busy", 64'({done, err, busy}), 64'b100);
        check("j1_cycle_cnt", 64'(cycle_cnt), 64'd80);
        check("j1_busy_cycles", 64'(n_busy - b_busy), 64'd80);
        check("j1_busy_falls_with_done", 64'(t_bfall), 64'(t_drise));
        step();
        step();
        step();
        check("j1_cycle_cnt_hold", 64'(cycle_cnt), 64'd80);
        check("j1_done_hold", 64'(done), 64'd1);

        // Stale finish levels, W before FM, both together, then minimum latency
        run_job("j2_w_first", 10, 5, 5, 4, 11, 24);
        run_job("j3_same_cycle", 6, 6, 1, 1, 7, 13);
        run_job("j4_min_latency", 1, 1, 1, 1, 2, 8);

        // Zero dimension
        launch(16'd4, 16'd4, 16'd0);
        wait_end("zero", 10);
        check("zero_err_code", 64'({err, err_code}), {61'd0, 1'b1, 2'd1});
        check("zero_done", 64'(done), 64'd0);
        check("zero_no_pulses", 64'((n_rs - b_rs) + (n_cp - b_cp) + (n_wb - b_wb)), 64'd0);
        check("zero_busy_cycles", 64'(n_busy - b_busy), 64'd2);
        check("zero_cycle_cnt", 64'(cycle_cnt), 64'd2);

        // Timeout in CP_WAIT
        set_dly(1, 1, 0, 1);
        launch(16'd4, 16'd4, 16'd4);
        check("tmo_err_cleared", 64'({err, err_code}), 64'd0);
        wait_end("tmo", 300);
        check("tmo_err_code", 64'({err, err_code}), {61'd0, 1'b1, 2'd2});
        check("tmo_cycle_cnt", 64'(cycle_cnt), 64'd105);
        check("tmo_no_wb", 64'(n_wb - b_wb), 64'd0);
        check("tmo_done", 64'(done), 64'd0);

        // Abort during RS_WAIT
        set_dly(50, 50, 1, 1);
        launch(16'd4, 16'd4, 16'd4);
        wait_pulse("abort_rs", b_rs, 1'b0, 20);
        step();
        step();
        step();
        host_abort = 1'b1;
        x_cyc = cyc;
        step();
        host_abort = 1'b0;
        check("abort_code_next", 64'({err_code, err, busy}), {60'd0, 2'd3, 1'b0, 1'b1});
        step();
        check("abort_err_busy", 64'({err, busy, done}), 64'b100);
        check("abort_cycle_cnt", 64'(cycle_cnt), 64'(x_cyc + 1 - a_cyc));
        check("abort_no_cp", 64'(n_cp - b_cp), 64'd0);

        // Reset during CP_WAIT, then a normal job
        set_dly(20, 25, 40, 10);
        launch(16'd7, 16'd7, 16'd7);
        wait_pulse("mrst_cp", b_cp, 1'b1, 100);
        step();
        step();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check("mrst_busy_done_err", 64'({busy, done, err}), 64'd0);
        check("mrst_err_code", 64'(err_code), 64'd0);
        check("mrst_dims", 64'({M, N, K}), 64'd0);
        check("mrst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("mrst_pulses", 64'({reshape_start, comp_start, wb_start}), 64'd0);
        rst = 1'b0;
        run_job("post_rst", 3, 2, 2, 2, 4, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tpu_seq_ctrl.md
Name: tpu_seq_ctrl

Overview:
Top-level sequencer for the naive TPU datapath. Latches the host job descriptor (M, N, K) and runs one job in four phases: FM and weight reshape in parallel, then systolic compute, then result write-back. It drives the start pulses of FM_reshape, W_reshape, the PE-array controller and the write-back unit, and collects their level-type finish flags. It reports busy, done, error and cycle count to the host register file.

Parameters:
DIM_W, 16, width of the M/N/K dimension fields
TIMEOUT, 1048575, maximum cycles spent in any single WAIT state before the job aborts
CNT_W, 32, width of the performance cycle counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
host_start  in  1  one-cycle job launch pulse; ignored unless idle
host_M  in  DIM_W  feature-map rows, sampled on an accepted host_start
host_N  in  DIM_W  feature-map columns / shared dimension
host_K  in  DIM_W  weight columns
host_abort  in  1  one-cycle pulse; aborts the running job
M, N, K  out  DIM_W each  latched dimensions fanned out to all sub-blocks
reshape_start  out  1  one-cycle pulse to FM_reshape and W_reshape
FM_reshape_finish  in  1  level; cleared by the sub-block after start
W_reshape_finish  in  1  level
comp_start  out  1  one-cycle pulse to the PE-array controller
comp_finish  in  1  level
wb_start  out  1  one-cycle pulse to the write-back unit
wb_finish  in  1  level
busy  out  1  high from an accepted start until DONE or ERR exits
done  out  1  level; set at job completion, cleared by the next accepted host_start
err  out  1  level; set on zero dimension, timeout or abort, cleared by the next accepted host_start
err_code  out  2  0=none, 1=zero dim, 2=timeout, 3=abort
cycle_cnt  out  CNT_W  cycles from accepted start to DONE; holds its value afterwards

Behaviour:
- Reset (sync, rst high at posedge): state IDLE, all pulses 0, busy/done/err 0, err_code 0, M/N/K 0, cycle_cnt 0, internal flags and timer 0.
- States: IDLE, CHECK, RS_LAUNCH, RS_WAIT, CP_LAUNCH, CP_WAIT, WB_LAUNCH, WB_WAIT, DONE, ERR.
- IDLE: host_start=1 latches host_M/N/K, clears done/err/err_code/cycle_cnt, sets busy, and moves to CHECK. When not idle, host_start has no effect.
- CHECK (1 cycle): any of M, N, K equal to 0 goes to ERR with err_code=1; otherwise RS_LAUNCH.
- Each LAUNCH state lasts exactly 1 cycle, and the matching *_start output is registered high during that cycle only. The next state is the matching WAIT state. The timer and the finish flags clear on entry to WAIT.
- Finish levels are not sampled in LAUNCH states, because the sub-block finish is still high from the previous job for up to 1 cycle after its start. Sampling begins in the first WAIT cycle.
- RS_WAIT: sticky flags fm_ok and w_ok capture the two finish levels, which may arrive in either order or the same cycle. When both are set, go to CP_LAUNCH.
- CP_WAIT: comp_finish=1 goes to WB_LAUNCH.
- WB_WAIT: wb_finish=1 goes to DONE.
- Timeout: in every WAIT state the timer increments each cycle. Reaching TIMEOUT goes to ERR with err_code=2.
- host_abort in any state other than IDLE, DONE or ERR goes to ERR with err_code=3 next cycle. Abort takes priority over finish or timeout in the same cycle. Sub-blocks are not reset by this block.
- DONE (1 cycle): done<=1, busy<=0, then back to IDLE.
- ERR (1 cycle): err<=1, busy<=0, then IDLE. done stays 0.
- cycle_cnt increments every cycle while busy=1 and saturates at all-ones.
- rst high mid-job returns to IDLE with all outputs at reset values next edge.
- Minimum job latency with sub-blocks finishing instantly: start to done = 8 cycles (CHECK, RS_L, RS_W, CP_L, CP_W, WB_L, WB_W, DONE).

Test Plan:
- Normal job: host_start with M=8,N=4,K=8; models assert FM finish 20 cycles after reshape_start and W finish 25 cycles after, comp_finish 40 cycles and wb_finish 10 cycles after their starts -> each *_start is exactly one 1-cycle pulse in order; done=1, err=0, busy falls with done; cycle_cnt matches the counted cycles.
- Stale finish: all finish levels held high from the previous job until 1 cycle after each start -> no phase is skipped; reshape_start→comp_start gap equals the real finish delay, not 2 cycles.
- Finish order: W_reshape_finish 5 cycles before FM_reshape_finish, then both in the same cycle on a rerun -> comp_start fires the cycle after the later flag is seen, in both runs.
- Zero dimension: host_start with K=0 -> err=1, err_code=1, no *_start pulse, busy high for 2 cycles.
- Timeout/abort: TIMEOUT=100 and comp_finish never asserts -> err_code=2 after 100 CP_WAIT cycles. A separate run with host_abort during RS_WAIT -> err_code=3 next cycle. A host_start issued mid-job is ignored.
- Reset mid-job: rst during CP_WAIT -> next edge all outputs 0, state IDLE; a new host_start then runs a full job normally.
